// File: rtl/riscv_pkg.sv
// riscv_pkg: shared control-word layout, bubble encoding and base opcodes for the RV64 pipeline
package riscv_pkg;
    localparam int CTRL_W = 8;
    localparam int CTRL_ALU_SRC = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_REG_WRITE = 5;
    localparam int CTRL_MEM_READ = 4;
    localparam int CTRL_MEM_WRITE = 3;
    localparam int CTRL_BRANCH = 2;
    localparam int CTRL_ALU_OP_HI = 1;
    localparam int CTRL_ALU_OP_LO = 0;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 8'h00;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in ID/EX whose destination feeds the instruction in ID
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              hazard
);
    assign hazard = ex_mem_read & ex_valid & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush and hold.
// Define ID_EX_STALL_COUNT_EN to build the saturating stall-cycle counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [XLEN-1:0]   i_rdata1,
    input  logic [XLEN-1:0]   i_rdata2,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [3:0]        i_funct,
    input  logic              i_flush,
    input  logic              i_hold,
    output logic              o_pc_write,
    output logic              o_if_id_write,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic [REG_AW-1:0] o_rd,
    output logic [XLEN-1:0]   o_rdata1,
    output logic [XLEN-1:0]   o_rdata2,
    output logic [XLEN-1:0]   o_imm,
    output logic [3:0]        o_funct,
    output logic [31:0]       o_stall_count
);
    logic hazard;
    logic stall;
    logic bubble;

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .ex_mem_read(o_ctrl[CTRL_MEM_READ]),
        .ex_valid   (o_valid),
        .ex_rd      (o_rd),
        .id_valid   (i_id_valid),
        .id_rs1     (i_rs1),
        .id_rs2     (i_rs2),
        .hazard     (hazard)
    );

    assign stall = hazard & ~i_flush & ~i_hold;
    assign bubble = i_flush | stall;
    assign o_pc_write = ~(stall | i_hold);
    assign o_if_id_write = o_pc_write;

    // Data fields always load when not held; only ctrl/valid are squashed to form a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ctrl   <= CTRL_BUBBLE;
            o_valid  <= 1'b0;
            o_rs1    <= '0;
            o_rs2    <= '0;
            o_rd     <= '0;
            o_rdata1 <= '0;
            o_rdata2 <= '0;
            o_imm    <= '0;
            o_funct  <= '0;
        end else if (!i_hold) begin
            o_ctrl   <= (bubble | ~i_id_valid) ? CTRL_BUBBLE : i_ctrl;
            o_valid  <= ~bubble & i_id_valid;
            o_rs1    <= i_rs1;
            o_rs2    <= i_rs2;
            o_rd     <= i_rd;
            o_rdata1 <= i_rdata1;
            o_rdata2 <= i_rdata2;
            o_imm    <= i_imm;
            o_funct  <= i_funct;
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_stall_count <= '0;
        else if (stall && o_stall_count != '1)
            o_stall_count <= o_stall_count + 32'd1;
    end
`else
    assign o_stall_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed load-use/flush/hold/reset scenarios plus random traffic checked against a behavioural model
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [7:0]  ctrl = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [63:0] rdata1 = '0, rdata2 = '0, imm = '0;
    logic [3:0]  funct = '0;
    logic        flush = 1'b0, hold = 1'b0;
    logic        pc_write, if_id_write, o_valid;
    logic [7:0]  o_ctrl;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [63:0] o_rdata1, o_rdata2, o_imm;
    logic [3:0]  o_funct;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_ctrl = '0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [63:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
    logic [3:0]  m_funct = '0;
    logic [31:0] m_cnt = '0;

    id_ex_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_ctrl(ctrl),
        .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_rdata1(rdata1), .i_rdata2(rdata2),
        .i_imm(imm), .i_funct(funct), .i_flush(flush), .i_hold(hold),
        .o_pc_write(pc_write), .o_if_id_write(if_id_write), .o_ctrl(o_ctrl),
        .o_valid(o_valid), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_rdata1(o_rdata1), .o_rdata2(o_rdata2), .o_imm(o_imm), .o_funct(o_funct),
        .o_stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A load in EX (mem_read bit 4) whose nonzero rd matches a source of a valid ID instruction.
    function automatic logic m_stall();
        return m_valid && m_ctrl[4] && m_rd != 0 && id_valid &&
               (m_rd == rs1 || m_rd == rs2) && !flush && !hold;
    endfunction

    always @(posedge clk) begin : model
        logic s;
        if (rst_n) begin
            s = m_stall();
            if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (!hold) begin
                m_valid = id_valid && !flush && !s;
                m_ctrl = m_valid ? ctrl : 8'h00;
                m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
                m_d1 = rdata1; m_d2 = rdata2; m_imm = imm; m_funct = funct;
            end
        end
    end

    always @(negedge rst_n) begin
        m_ctrl = '0; m_valid = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_d1 = '0; m_d2 = '0; m_imm = '0; m_funct = '0; m_cnt = '0;
    end

    always @(negedge clk) begin
        chk("ctrl", o_ctrl, m_ctrl);
        chk("valid", o_valid, m_valid);
        chk("rs1", o_rs1, m_rs1);
        chk("rs2", o_rs2, m_rs2);
        chk("rd", o_rd, m_rd);
        if (m_valid) begin
            chk("rdata1", o_rdata1, m_d1);
            chk("rdata2", o_rdata2, m_d2);
            chk("imm", o_imm, m_imm);
            chk("funct", o_funct, m_funct);
        end
        chk("pc_write", pc_write, !(m_stall() || hold));
        chk("if_id_write", if_id_write, !(m_stall() || hold));
`ifdef ID_EX_STALL_COUNT_EN
        chk("stall_count", stall_count, m_cnt);
`else
        chk("stall_count", stall_count, 0);
`endif
    end

    task automatic drv(input logic v, input logic [7:0] c, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic f, input logic h);
        @(posedge clk);
        #1;
        id_valid = v; ctrl = c; rs1 = a; rs2 = b; rd = d; flush = f; hold = h;
        rdata1 = {$urandom, $urandom}; rdata2 = {$urandom, $urandom};
        imm = {$urandom, $urandom}; funct = 4'($urandom);
        #1;
    endtask

    initial begin
        drv(0, 8'h00, 0, 0, 0, 0, 0);
        chk("rst_ctrl", o_ctrl, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_count", stall_count, 0);
        rst_n = 1;
        drv(1, 8'hF0, 1, 2, 5, 0, 0);
        drv(1, 8'h22, 5, 7, 6, 0, 0);
        chk("ld_ctrl", o_ctrl, 8'hF0);
        chk("ld_rd", o_rd, 5);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_if_id_write", if_id_write, 0);
        drv(1, 8'h22, 5, 7, 6, 0, 0);
        chk("bubble_ctrl", o_ctrl, 0);
        chk("bubble_valid", o_valid, 0);
        chk("after_bubble_pc_write", pc_write, 1);
        drv(1, 8'hF0, 1, 2, 0, 0, 0);
        chk("add_ctrl", o_ctrl, 8'h22);
        chk("add_rs1", o_rs1, 5);
        chk("add_rd", o_rd, 6);
        drv(1, 8'h22, 0, 0, 3, 0, 0);
        chk("ldx0_ctrl", o_ctrl, 8'hF0);
        chk("ldx0_pc_write", pc_write, 1);
        drv(1, 8'hF0, 1, 2, 5, 0, 0);
        drv(1, 8'h22, 5, 5, 6, 1, 0);
        chk("flush_pc_write", pc_write, 1);
        drv(1, 8'h22, 5, 5, 6, 0, 0);
        chk("flush_ctrl", o_ctrl, 0);
        chk("flush_valid", o_valid, 0);
        chk("post_flush_pc_write", pc_write, 1);
        drv(1, 8'h22, 1, 2, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'hF0, 3, 4, 7, 0, 1);
            chk("hold_ctrl", o_ctrl, 8'h22);
            chk("hold_rd", o_rd, 9);
            chk("hold_pc_write", pc_write, 0);
        end
        drv(1, 8'hF0, 3, 4, 7, 0, 0);
        chk("release_ctrl", o_ctrl, 8'h22);
        chk("release_rd", o_rd, 9);
        drv(1, 8'h22, 7, 0, 1, 0, 0);
        chk("release_load_ctrl", o_ctrl, 8'hF0);
        chk("release_load_rd", o_rd, 7);
        chk("stall2_pc_write", pc_write, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_ctrl", o_ctrl, 0);
        chk("async_rst_rd", o_rd, 0);
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_pc_write", pc_write, 1);
        chk("async_rst_count", stall_count, 0);
        rst_n = 1;
        drv(1, 8'h22, 7, 0, 1, 0, 0);
        chk("post_rst_ctrl", o_ctrl, 8'h22);
        chk("post_rst_valid", o_valid, 1);
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'hF0, 0, 0, 5, 0, 0);
            drv(1, 8'h22, 5, 0, 6, 0, 0);
            chk("pair_pc_write", pc_write, 0);
            drv(1, 8'h22, 5, 0, 6, 0, 0);
            drv(1, 8'h22, 1, 2, 3, 0, 0);
        end
        drv(0, 8'h00, 0, 0, 0, 0, 0);
`ifdef ID_EX_STALL_COUNT_EN
        chk("count4", stall_count, 4);
`else
        chk("count0", stall_count, 0);
`endif
        for (int i = 0; i < 3000; i++)
            drv($urandom_range(0, 9) < 8, 8'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage for the 5-stage RV64 core.
- Registers decoded control bits and operands, and supplies rs1/rs2/rd to the forwarding unit and control bits to EX.
- Detects load-use hazards: stalls PC and IF/ID for one cycle and inserts a bubble.
- Handles branch flush and global hold.

Parameters:
- XLEN, 64, datapath width for register read data and immediate.
- REG_AW, 5, register address width.

Ports:
- i_clk  input  1  core clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_id_valid  input  1  IF/ID holds a real instruction.
- i_ctrl  input  8  decoded control {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}.
- i_rs1, i_rs2, i_rd  input  REG_AW each  register fields from IF/ID.
- i_rdata1, i_rdata2  input  XLEN each  register file read data.
- i_imm  input  XLEN  sign-extended immediate.
- i_funct  input  4  {instr[30], funct3}.
- i_flush  input  1  branch taken; squash the instruction in ID.
- i_hold  input  1  global freeze (memory wait).
- o_pc_write  output  1  PC update enable.
- o_if_id_write  output  1  IF/ID update enable.
- o_ctrl  output  8  registered control.
- o_valid  output  1  registered valid.
- o_rs1, o_rs2, o_rd  output  REG_AW each  registered register fields.
- o_rdata1, o_rdata2, o_imm  output  XLEN each  registered operands.
- o_funct  output  4  registered funct.
- o_stall_count  output  32  stall-cycle counter.

Behaviour:
- Reset (async, i_rst_n=0): every registered output = 0. o_ctrl=0 is a bubble. o_stall_count=0. o_pc_write=o_if_id_write=1, because they are combinational from the zero state.
- Hazard (combinational):
  - hazard = o_ctrl[4] (mem_read) & o_valid & (o_rd!=0) & i_id_valid & (o_rd==i_rs1 | o_rd==i_rs2).
  - stall = hazard & ~i_flush & ~i_hold.
- o_pc_write = o_if_id_write = ~(stall | i_hold).
- Register update on posedge i_clk, in priority order:
  1. i_hold=1: all ID/EX registers keep their value; i_flush is ignored. Upstream keeps i_flush high until hold drops.
  2. i_flush=1: o_ctrl=0, o_valid=0. Data fields load normally (don't-care).
  3. stall=1: o_ctrl=0, o_valid=0 (bubble). Data fields load normally.
  4. Otherwise: all fields load from inputs; o_valid=i_id_valid; o_ctrl=i_ctrl if i_id_valid, else 0.
- Latency: 1 cycle from ID inputs to outputs.
- A load-use hazard stalls exactly 1 cycle. After the stall the bubble has mem_read=0, so hazard deasserts and the held instruction issues with the load in MEM, where MEM/WB forwarding resolves it.
- A load with rd=x0 never stalls.
- Hazard on both rs1 and rs2 at once still stalls 1 cycle.
- Reset asserted mid-stall: outputs clear immediately. No stall is pending after release.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- Defined: o_stall_count increments on every cycle with stall=1 and saturates at 32'hFFFF_FFFF. Cleared only by reset; i_hold does not count.
- Undefined: o_stall_count tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package riscv_pkg holds:
  - CTRL_W=8 and the control bit indices (CTRL_ALU_SRC=7 … CTRL_ALU_OP=1:0).
  - CTRL_BUBBLE=8'h00.
  - Opcode constants OP_RTYPE=7'b0110011, OP_LD=7'b0000011, OP_SD=7'b0100011, OP_BEQ=7'b1100011.
- One natural sub-module, load_use_detect: the combinational hazard compare, instantiated once.

Test Plan:
- Reset with i_rst_n=0 mid-run -> all outputs 0 and o_pc_write=1 asynchronously, before the next clock edge.
- ld x5 in ID/EX (o_ctrl=8'hF0, o_rd=5); ID add x6,x5,x7 (i_rs1=5) -> o_pc_write=0 and o_if_id_write=0 for 1 cycle, then o_ctrl=0 and o_valid=0. Next cycle the add issues with o_ctrl=8'h22 and o_rs1=5.
- ld x0 in ID/EX; ID uses i_rs1=0 -> no stall, o_pc_write stays 1.
- Hazard condition with i_flush=1 the same cycle -> o_pc_write=1 and bubble captured. Next cycle no stall.
- i_hold=1 for 3 cycles with o_rd=9 and o_ctrl=8'h22 held -> outputs unchanged and o_pc_write=0 throughout. Release -> normal load.
- With ID_EX_STALL_COUNT_EN: 4 separate load-use pairs -> o_stall_count=4. Without the macro -> o_stall_count=0.
